tpu_mmio_regs: RTL

MMIO responder and register file for the TPU: decodes the 16-bit MMIO bus, holds the A and B operand matrices, and exposes ID, VER, CTRL, STATUS and the C result window. It sits between the host-side MMIO initiator and the systolic compute core inside `tpu_top`. It launches the core on a CTRL write, tracks busy/done, and captures the core's result matrix for readback.

---
 rtl/tpu_pkg.sv | 30 +++
 rtl/tpu_mat_regfile.sv | 51 +++++
 rtl/tpu_mmio_regs.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared constants for the TPU MMIO block: address map, identity words,
// register bit positions and the control state encoding.
package tpu_pkg;

    localparam logic [15:0] ADDR_ID     = 16'h0000;
    localparam logic [15:0] ADDR_VER    = 16'h0004;
    localparam logic [15:0] ADDR_CTRL   = 16'h0008;
    localparam logic [15:0] ADDR_STATUS = 16'h000C;

    // Matrix windows occupy whole 256-byte pages; the low byte is the element index.
    localparam logic [7:0] PAGE_A = 8'h01;
    localparam logic [7:0] PAGE_B = 8'h02;
    localparam logic [7:0] PAGE_C = 8'h03;

    localparam logic [31:0] ID_VALUE  = 32'h5450_5531;
    localparam logic [31:0] VER_VALUE = 32'h0001_0000;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    // Encoded as {busy, done}.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b01
    } state_t;

endpackage

// File: rtl/tpu_mat_regfile.sv
// N*N x W register bank: single indexed write, optional full-bank parallel
// load, combinational indexed read and a flattened view of every element.
module tpu_mat_regfile #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [W-1:0]         wr_data,
    input  logic                 load_en,
    input  logic [DEPTH*W-1:0]   load_data,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [W-1:0]         rd_data,
    output logic [DEPTH*W-1:0]   flat
);

    logic [W-1:0] mem_reg [DEPTH];

    // Parallel load has priority; the two ports are never used on the same bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= load_data[i*W +: W];
            end
        end else if (wr_en) begin
            mem_reg[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_idx) < 32'(DEPTH)) begin
            rd_data = mem_reg[rd_idx];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign flat[gi*W +: W] = mem_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/tpu_mmio_regs.sv
// MMIO responder for the TPU: decodes the register map, holds the A/B operand
// banks, launches the compute core and captures its result into the C bank.
module tpu_mmio_regs
    import tpu_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mmio_wr,
    input  logic                      mmio_rd,
    input  logic [15:0]               mmio_addr,
    input  logic [31:0]               mmio_wdata,
    input  logic [3:0]                mmio_wstrb,
    output logic [31:0]               mmio_rdata,
    output logic                      mmio_ready,
    output logic                      core_start,
    output logic [N*N*DATA_W-1:0]     core_a,
    output logic [N*N*DATA_W-1:0]     core_b,
    input  logic                      core_done,
    input  logic [N*N*SUM_W-1:0]      core_c
);

    localparam int DEPTH = N * N;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t state_reg, state_next;
    logic   start_reg;

    logic [7:0]       page;
    logic [7:0]       offset;
    logic [IDX_W-1:0] idx;
    logic             idx_ok;
    logic             busy;
    logic             done_flag;
    logic             ctrl_wr;
    logic             start_req;
    logic             clear_req;
    logic             done_evt;
    logic             a_wr;
    logic             b_wr;
    logic [DATA_W-1:0] a_rd;
    logic [DATA_W-1:0] b_rd;
    logic [SUM_W-1:0]  c_rd;
    logic [DEPTH*SUM_W-1:0] c_bank_unused;
    logic             wdata_unused;

    assign page   = mmio_addr[15:8];
    assign offset = mmio_addr[7:0];
    assign idx    = offset[IDX_W-1:0];
    assign idx_ok = 32'(offset) < 32'(DEPTH);

    assign busy      = (state_reg == ST_RUN);
    assign done_flag = (state_reg == ST_DONE);

    assign ctrl_wr   = mmio_wr && (mmio_addr == ADDR_CTRL) && mmio_wstrb[0];
    assign start_req = ctrl_wr && mmio_wdata[CTRL_START_BIT] && !busy;
    assign clear_req = ctrl_wr && mmio_wdata[CTRL_CLEAR_BIT];
    assign done_evt  = core_done && busy;

    // Operands are frozen while the core is running.
    assign a_wr = mmio_wr && (page == PAGE_A) && idx_ok && mmio_wstrb[0] && !busy;
    assign b_wr = mmio_wr && (page == PAGE_B) && idx_ok && mmio_wstrb[0] && !busy;

    assign mmio_ready   = mmio_wr | mmio_rd;
    assign core_start   = start_reg;
    assign wdata_unused = ^{mmio_wdata, mmio_wstrb[3:1], c_bank_unused};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            start_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            start_reg <= start_req;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (start_req) state_next = ST_RUN;
            ST_RUN:  if (done_evt)  state_next = ST_DONE;
            ST_DONE: begin
                if (start_req)      state_next = ST_RUN;
                else if (clear_req) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    tpu_mat_regfile #(.DEPTH(DEPTH), .W(DATA_W)) u_bank_a (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (a_wr),
        .wr_idx    (idx),
        .wr_data   (mmio_wdata[DATA_W-1:0]),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_idx    (idx),
        .rd_data   (a_rd),
        .flat      (core_a)
    );

    tpu_mat_regfile #(.DEPTH(DEPTH), .W(DATA_W)) u_bank_b (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (b_wr),
        .wr_idx    (idx),
        .wr_data   (mmio_wdata[DATA_W-1:0]),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_idx    (idx),
        .rd_data   (b_rd),
        .flat      (core_b)
    );

    tpu_mat_regfile #(.DEPTH(DEPTH), .W(SUM_W)) u_bank_c (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .load_en   (done_evt),
        .load_data (core_c),
        .rd_idx    (idx),
        .rd_data   (c_rd),
        .flat      (c_bank_unused)
    );

    // A simultaneous write takes the cycle, so read data stays 0.
    always_comb begin
        mmio_rdata = '0;
        if (mmio_rd && !mmio_wr) begin
            if (mmio_addr == ADDR_ID) begin
                mmio_rdata = ID_VALUE;
            end else if (mmio_addr == ADDR_VER) begin
                mmio_rdata = VER_VALUE;
            end else if (mmio_addr == ADDR_STATUS) begin
                mmio_rdata[STATUS_BUSY_BIT] = busy;
                mmio_rdata[STATUS_DONE_BIT] = done_flag;
            end else if (page == PAGE_A && idx_ok) begin
                mmio_rdata = 32'(a_rd);
            end else if (page == PAGE_B && idx_ok) begin
                mmio_rdata = 32'(b_rd);
            end else if (page == PAGE_C && idx_ok) begin
                mmio_rdata = 32'(c_rd);
            end
        end
    end

endmodule
